// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: tracks HI/LO occupancy, commits results after a fixed latency,
// and raises an ID-stage stall. Optional flush input enabled by `define MD_CANCEL_EN.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        id_uses_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);

  localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_we_q, pend_we_d;

  logic        cancel_w;
  logic        is_mul_op, is_div_op, start;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b, div_b, quo, rem, q_res, r_res;

`ifdef MD_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  assign busy      = (state_q == S_RUN);
  assign is_mul_op = (md_op == 3'd1) || (md_op == 3'd2);
  assign is_div_op = (md_op == 3'd3) || (md_op == 3'd4);
  assign start     = (is_mul_op || is_div_op) && !busy;
  assign stall_md  = id_uses_md && (busy || start);
  assign hi        = hi_q;
  assign lo        = lo_q;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN without special casing.
  assign a_neg = (md_op == 3'd3) && rs_val[31];
  assign b_neg = (md_op == 3'd3) && rt_val[31];
  assign mag_a = a_neg ? (32'd0 - rs_val) : rs_val;
  assign mag_b = b_neg ? (32'd0 - rt_val) : rt_val;
  assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign quo   = mag_a / div_b;
  assign rem   = mag_a % div_b;
  assign q_res = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
  assign r_res = a_neg ? (32'd0 - rem) : rem;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      S_IDLE: begin
        if (!cancel_w) begin
          if (start) begin
            state_d = S_RUN;
            if (is_mul_op) begin
              cnt_d     = MUL_LOAD;
              pend_hi_d = (md_op == 3'd1) ? prod_s[63:32] : prod_u[63:32];
              pend_lo_d = (md_op == 3'd1) ? prod_s[31:0]  : prod_u[31:0];
              pend_we_d = 1'b1;
            end else begin
              cnt_d     = DIV_LOAD;
              pend_hi_d = r_res;
              pend_lo_d = q_res;
              pend_we_d = (rt_val != 32'd0);
            end
          end else if (md_op == 3'd5) begin
            hi_d = rs_val;
          end else if (md_op == 3'd6) begin
            lo_d = rs_val;
          end
        end
      end
      S_RUN: begin
        if (cancel_w) begin
          state_d   = S_IDLE;
          cnt_d     = 4'd0;
          pend_we_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d   = S_IDLE;
          pend_we_d = 1'b0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: behavioural HI/LO model compared every cycle,
// plus directed literal expectations.
module tb_md_scheduler;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        id_uses_md = 1'b0;
  logic        cancel_tb = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall_md;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef MD_CANCEL_EN
    .cancel     (cancel_tb),
`endif
    .md_op      (md_op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .id_uses_md (id_uses_md),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .stall_md   (stall_md)
  );

  // Model: remaining busy cycles plus the result waiting to land.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  int          m_rem = 0;
  bit          m_pv = 1'b0;
  logic signed [63:0] sa, sb, sp, sq, sr;
  logic [63:0] ua, ub, up, uq, ur;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi = 32'd0; m_lo = 32'd0; m_rem = 0; m_pv = 1'b0;
    end else if (cancel_tb) begin
      m_rem = 0; m_pv = 1'b0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0 && m_pv) begin
        m_hi = m_phi; m_lo = m_plo;
      end
      if (m_rem == 0) m_pv = 1'b0;
    end else begin
      sa = $signed(rs_val); sb = $signed(rt_val);
      ua = {32'd0, rs_val}; ub = {32'd0, rt_val};
      case (md_op)
        3'd1: begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0]; m_pv = 1'b1; m_rem = MC; end
        3'd2: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; m_pv = 1'b1; m_rem = MC; end
        3'd3: begin
          m_rem = DC; m_pv = (rt_val != 32'd0);
          if (m_pv) begin sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0]; end
        end
        3'd4: begin
          m_rem = DC; m_pv = (rt_val != 32'd0);
          if (m_pv) begin uq = ua / ub; ur = ua % ub; m_plo = uq[31:0]; m_phi = ur[31:0]; end
        end
        3'd5: m_hi = rs_val;
        3'd6: m_lo = rs_val;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic exp_stall, exp_busy;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_busy  = (m_rem != 0);
      exp_stall = id_uses_md && (exp_busy || (md_op >= 3'd1 && md_op <= 3'd4));
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
      chk("model_busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("model_stall", {31'd0, stall_md}, {31'd0, exp_stall});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    md_op = op; rs_val = a; rt_val = b;
    #1;
  endtask

  // Counts busy and stall cycles until busy drops; leaves md_op at 0.
  task automatic wait_idle(output int nb, output int ns);
    bit done;
    done = 1'b0; nb = 0; ns = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      md_op = 3'd0;
      #1;
      if (busy) begin
        nb++;
        if (stall_md) ns++;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout actual=busy required=idle at %0t", $time);
    end
  endtask

  int nb, ns;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall_md}, 32'd0);
    repeat (3) issue(3'd0, 32'd0, 32'd0);

    // mult -2 * 3
    issue(3'd1, 32'hFFFFFFFE, 32'h00000003);
    wait_idle(nb, ns);
    chk("mult_busy_cycles", 32'(nb), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    // divu 100 / 7 with an mflo waiting in ID
    id_uses_md = 1'b1;
    issue(3'd4, 32'd100, 32'd7);
    chk("divu_stall_start", {31'd0, stall_md}, 32'd1);
    wait_idle(nb, ns);
    chk("divu_busy_cycles", 32'(nb), 32'd10);
    chk("divu_stall_cycles", 32'(ns), 32'd10);
    chk("divu_stall_end", {31'd0, stall_md}, 32'd0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    id_uses_md = 1'b0;

    // INT_MIN / -1, then divide by zero leaves HI/LO alone
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(nb, ns);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(nb, ns);
    chk("div0_busy_cycles", 32'(nb), 32'd10);
    chk("div0_lo", lo, 32'h80000000);
    chk("div0_hi", hi, 32'd0);

    // signed remainder follows dividend: -7 / 2 = -3 r -1
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(nb, ns);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);

    // mthi / mtlo back to back
    issue(3'd5, 32'h12345678, 32'd0);
    issue(3'd6, 32'h9ABCDEF0, 32'd0);
    chk("mthi_hi", hi, 32'h12345678);
    issue(3'd0, 32'd0, 32'd0);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);

    // ops presented while busy are ignored; no stall without an MD user in ID
    issue(3'd1, 32'd3, 32'd4);
    issue(3'd1, 32'd7, 32'd7);
    chk("busy_mult2", {31'd0, busy}, 32'd1);
    chk("stall_no_user", {31'd0, stall_md}, 32'd0);
    issue(3'd5, 32'hDEADBEEF, 32'd0);
    wait_idle(nb, ns);
    chk("ignore_busy_left", 32'(nb), 32'd3);
    chk("ignore_hi", hi, 32'd0);
    chk("ignore_lo", lo, 32'd12);

`ifdef MD_CANCEL_EN
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    issue(3'd0, 32'd0, 32'd0);
    issue(3'd0, 32'd0, 32'd0);
    cancel_tb = 1'b1;
    @(posedge clk); #1 cancel_tb = 1'b0;
    #1;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'd0);
    chk("cancel_lo", lo, 32'd12);
    @(posedge clk); #1;
    md_op = 3'd1; rs_val = 32'd5; rt_val = 32'd5; cancel_tb = 1'b1;
    @(posedge clk); #1;
    md_op = 3'd0; cancel_tb = 1'b0;
    #1;
    chk("cancel_start_busy", {31'd0, busy}, 32'd0);
    chk("cancel_start_lo", lo, 32'd12);
`endif

    // async reset in the middle of a divide
    issue(3'd3, 32'd100, 32'd7);
    issue(3'd0, 32'd0, 32'd0);
    issue(3'd0, 32'd0, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    issue(3'd4, 32'd9, 32'd2);
    wait_idle(nb, ns);
    chk("post_rst_lo", lo, 32'd4);
    chk("post_rst_hi", hi, 32'd1);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Sequences the shared multiply/divide resource (HI/LO) for the 5-stage MIPS pipeline.
- Accepts MD operations issued from EX and models their multi-cycle latency with a busy counter.
- Commits HI/LO when the operation completes.
- Generates a stall request that the hazard logic ORs into the ID-stage stall whenever the instruction in ID touches HI/LO while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu; legal range 1..15.
- DIV_CYCLES, 10, busy duration for div/divu; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- md_op  input  3  EX-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_val  input  32  forwarded rs operand from EX.
- rt_val  input  32  forwarded rt operand from EX.
- id_uses_md  input  1  ID-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- busy  output  1  operation in flight.
- stall_md  output  1  stall request for ID.

Behaviour:
- Reset: while reset_n=0, asynchronously hi=0, lo=0, busy=0, state=IDLE, counter=0, pending registers=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- start = (md_op in 1..4) & ~busy.
- IDLE → RUN on edge with start=1:
  - Result is computed from rs_val/rt_val and captured in pend_hi/pend_lo.
  - Counter loaded with (MULT_CYCLES-1) for op 1/2, or (DIV_CYCLES-1) for op 3/4.
- RUN: counter decrements each edge.
  - At the edge where counter==0: hi/lo ← pend_hi/pend_lo, state → IDLE.
  - Net effect: busy is high for exactly N cycles after the start edge, and HI/LO become visible in the same cycle busy falls.
- Arithmetic:
  - mult: signed 64-bit product; hi=[63:32], lo=[31:0].
  - multu: same as mult, unsigned.
  - div: lo=signed quotient truncated toward zero; hi=remainder with sign of dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (rt_val=0): unit still runs DIV_CYCLES; hi/lo unchanged at completion (pending write suppressed).
- mthi/mtlo:
  - Accepted only when busy=0: hi (or lo) ← rs_val at next edge; no busy.
  - md_op 5/6 while busy=1: ignored, no state change (cannot occur under correct stalling; bench checks stall prevents it).
- md_op 1..4 while busy=1: ignored; in-flight op unaffected.
- stall_md = id_uses_md & (busy | start). Purely combinational, no registered delay.
  - Covers both the in-flight op and the op starting this cycle.
  - Deasserts in the cycle busy falls, so mfhi/mflo in ID then reads the updated hi/lo.
- hi/lo outputs are registers, read directly by ID/EX mfhi/mflo paths. No internal bypass: mthi followed by mfhi sees the new value one cycle later, which matches normal pipeline spacing.
- Reset mid-RUN: aborts the op; hi/lo return to 0; busy=0 immediately (async).

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit), driven by the exception/flush logic.
  - cancel=1 at an edge while busy=1: state → IDLE, counter → 0, hi/lo unchanged, pending discarded.
  - cancel=1 while busy=0: also suppresses a start or mthi/mtlo presented in that cycle.
  - cancel has priority over completion in the same cycle (counter==0): no commit.
- Not defined: port absent; every started op always commits per normal rules.

Test Plan:
- Reset release, md_op=0 → hi=0, lo=0, busy=0, stall_md=0 for 3 cycles.
- mult, rs=0xFFFFFFFE (-2), rt=0x00000003, MULT_CYCLES=5 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu, rs=100, rt=7, id_uses_md=1 held (mflo waiting) → stall_md=1 in the start cycle plus 10 busy cycles, 0 on the 11th; lo=14, hi=2.
- div, rs=0x80000000, rt=0xFFFFFFFF → lo=0x80000000, hi=0.
  - Then div by rt=0 → busy 10 cycles, hi/lo unchanged.
- mthi rs=0x12345678 then mtlo rs=0x9ABCDEF0 on consecutive cycles → hi/lo updated one edge after each.
  - mult issued while busy is ignored; stall_md=0 when id_uses_md=0 even while busy.
- MD_CANCEL_EN: start multu, cancel at busy cycle 3 → busy=0 next cycle, hi/lo keep prior values.
  - Separately, reset_n pulse mid-div → hi=lo=0, busy=0 asynchronously.
